// File: rtl/lockin_mixer_mc.sv
// lockin_mixer_mc: time-multiplexed multi-channel I/Q mixer.
// A frame latches NUM_CH samples plus one sine/cosine pair, then streams
// channel products through a single multiplier pair. Each product is rounded,
// shifted, saturated and tagged with its channel index.
module lockin_mixer_mc #(
  parameter int DATA_WIDTH = 24,
  parameter int SIN_WIDTH  = 18,
  parameter int NUM_CH     = 4,
  parameter int SHIFT      = 0,
  parameter int OUT_WIDTH  = 42,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  data_in,
  input  logic signed [SIN_WIDTH-1:0]   sine_in,
  input  logic signed [SIN_WIDTH-1:0]   cosine_in,
  output logic                          busy,
  output logic signed [OUT_WIDTH-1:0]   phase_out,
  output logic signed [OUT_WIDTH-1:0]   quadrature_out,
  output logic [CH_W-1:0]               ch_out,
  output logic                          o_valid,
  output logic                          o_last,
  output logic                          o_sat,
  output logic                          o_drop
);

  localparam int PRODUCT_WIDTH = DATA_WIDTH + SIN_WIDTH;
  localparam int EXT_W         = PRODUCT_WIDTH + 1;
  localparam int CNT_W         = CH_W + 1;

  // Half-LSB of the shifted result; only meaningful when SHIFT > 0.
  localparam logic signed [EXT_W-1:0] ROUND_V = EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0);
  localparam logic signed [EXT_W-1:0] MAX_V =
    {{(EXT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V =
    {{(EXT_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                            state;
  logic signed [DATA_WIDTH-1:0]      data_reg [NUM_CH];
  logic signed [SIN_WIDTH-1:0]       sin_reg;
  logic signed [SIN_WIDTH-1:0]       cos_reg;
  logic [CNT_W-1:0]                  issue_cnt;
  logic signed [PRODUCT_WIDTH-1:0]   prod_i;
  logic signed [PRODUCT_WIDTH-1:0]   prod_q;
  logic                              prod_valid;
  logic                              prod_last;
  logic [CH_W-1:0]                   prod_ch;

  logic                              issue_active;
  logic                              finishing;
  logic                              accept;
  logic signed [DATA_WIDTH-1:0]      cur_data;
  logic signed [EXT_W-1:0]           sc_i;
  logic signed [EXT_W-1:0]           sc_q;
  logic signed [OUT_WIDTH-1:0]       res_i;
  logic signed [OUT_WIDTH-1:0]       res_q;
  logic                              sat_i;
  logic                              sat_q;

  // Round-half-up and arithmetic shift in one guard bit of headroom.
  function automatic logic signed [EXT_W-1:0] scale(input logic signed [PRODUCT_WIDTH-1:0] p);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(p);
    if (SHIFT > 0) e = (e + ROUND_V) >>> SHIFT;
    return e;
  endfunction

  // The frame ends at the edge registering the last channel; a start seen on
  // that same edge chains the next frame with no idle cycle.
  always_comb begin
    issue_active = (state == RUN) && (issue_cnt < CNT_W'(NUM_CH));
    finishing    = (state == RUN) && prod_valid && prod_last;
    accept       = start && reset_n && ((state == IDLE) || finishing);
  end

  // Select the latched sample of the channel currently being issued.
  always_comb begin
    cur_data = data_reg[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (issue_cnt == CNT_W'(k)) cur_data = data_reg[k];
    end
  end

  // Scale both products and clamp them into the output range.
  always_comb begin
    sc_i  = scale(prod_i);
    sc_q  = scale(prod_q);
    sat_i = 1'b0;
    sat_q = 1'b0;
    res_i = sc_i[OUT_WIDTH-1:0];
    res_q = sc_q[OUT_WIDTH-1:0];
    if (sc_i > MAX_V) begin
      res_i = MAX_V[OUT_WIDTH-1:0];
      sat_i = 1'b1;
    end else if (sc_i < MIN_V) begin
      res_i = MIN_V[OUT_WIDTH-1:0];
      sat_i = 1'b1;
    end
    if (sc_q > MAX_V) begin
      res_q = MAX_V[OUT_WIDTH-1:0];
      sat_q = 1'b1;
    end else if (sc_q < MIN_V) begin
      res_q = MIN_V[OUT_WIDTH-1:0];
      sat_q = 1'b1;
    end
  end

  // Frame capture and full-precision multiply; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_reg[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      sin_reg <= sine_in;
      cos_reg <= cosine_in;
    end
    if (issue_active) begin
      prod_i <= PRODUCT_WIDTH'(cur_data) * PRODUCT_WIDTH'(sin_reg);
      prod_q <= PRODUCT_WIDTH'(cur_data) * PRODUCT_WIDTH'(cos_reg);
    end
  end

  // Control FSM, issue-stage tags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      issue_cnt      <= '0;
      prod_valid     <= 1'b0;
      prod_last      <= 1'b0;
      prod_ch        <= '0;
      o_valid        <= 1'b0;
      o_last         <= 1'b0;
      o_sat          <= 1'b0;
      o_drop         <= 1'b0;
      phase_out      <= '0;
      quadrature_out <= '0;
      ch_out         <= '0;
    end else begin
      o_drop     <= start && (state == RUN) && !finishing;

      prod_valid <= issue_active;
      if (issue_active) begin
        prod_ch   <= issue_cnt[CH_W-1:0];
        prod_last <= (issue_cnt == CNT_W'(NUM_CH - 1));
        issue_cnt <= issue_cnt + CNT_W'(1);
      end

      o_valid <= prod_valid;
      o_last  <= prod_valid && prod_last;
      o_sat   <= prod_valid && (sat_i || sat_q);
      if (prod_valid) begin
        phase_out      <= res_i;
        quadrature_out <= res_q;
        ch_out         <= prod_ch;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            issue_cnt <= '0;
          end
        end
        RUN: begin
          if (finishing) begin
            if (start) begin
              issue_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockin_mixer_mc.sv
// tb_lockin_mixer_mc: directed and random scoreboard bench for the
// multi-channel lock-in mixer, covering four parameterisations.
module tb_lockin_mixer_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cycle  = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int     cyc;
    longint i;
    longint q;
    int     ch;
    bit     last;
    bit     sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];

  // Instance a: defaults (4 channels, full precision)
  logic               a_start;
  logic [95:0]        a_data;
  logic signed [17:0] a_sin, a_cos;
  logic               a_busy, a_valid, a_last, a_sat, a_drop;
  logic signed [41:0] a_i, a_q;
  logic [1:0]         a_ch;

  // Instance b: SHIFT=10, OUT_WIDTH=24, 2 channels
  logic               b_start;
  logic [47:0]        b_data;
  logic signed [17:0] b_sin, b_cos;
  logic               b_busy, b_valid, b_last, b_sat, b_drop;
  logic signed [23:0] b_i, b_q;
  logic [0:0]         b_ch;

  // Instance c: SHIFT=1, OUT_WIDTH=41, 2 channels
  logic               c_start;
  logic [47:0]        c_data;
  logic signed [17:0] c_sin, c_cos;
  logic               c_busy, c_valid, c_last, c_sat, c_drop;
  logic signed [40:0] c_i, c_q;
  logic [0:0]         c_ch;

  // Instance d: single channel, full precision
  logic               d_start;
  logic [23:0]        d_data;
  logic signed [17:0] d_sin, d_cos;
  logic               d_busy, d_valid, d_last, d_sat, d_drop;
  logic signed [41:0] d_i, d_q;
  logic [0:0]         d_ch;

  lockin_mixer_mc dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .data_in(a_data),
    .sine_in(a_sin), .cosine_in(a_cos), .busy(a_busy), .phase_out(a_i),
    .quadrature_out(a_q), .ch_out(a_ch), .o_valid(a_valid), .o_last(a_last),
    .o_sat(a_sat), .o_drop(a_drop)
  );

  lockin_mixer_mc #(.NUM_CH(2), .SHIFT(10), .OUT_WIDTH(24)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .data_in(b_data),
    .sine_in(b_sin), .cosine_in(b_cos), .busy(b_busy), .phase_out(b_i),
    .quadrature_out(b_q), .ch_out(b_ch), .o_valid(b_valid), .o_last(b_last),
    .o_sat(b_sat), .o_drop(b_drop)
  );

  lockin_mixer_mc #(.NUM_CH(2), .SHIFT(1), .OUT_WIDTH(41)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(c_start), .data_in(c_data),
    .sine_in(c_sin), .cosine_in(c_cos), .busy(c_busy), .phase_out(c_i),
    .quadrature_out(c_q), .ch_out(c_ch), .o_valid(c_valid), .o_last(c_last),
    .o_sat(c_sat), .o_drop(c_drop)
  );

  lockin_mixer_mc #(.NUM_CH(1), .SHIFT(0), .OUT_WIDTH(42)) dut_d (
    .clk(clk), .reset_n(reset_n), .start(d_start), .data_in(d_data),
    .sine_in(d_sin), .cosine_in(d_cos), .busy(d_busy), .phase_out(d_i),
    .quadrature_out(d_q), .ch_out(d_ch), .o_valid(d_valid), .o_last(d_last),
    .o_sat(d_sat), .o_drop(d_drop)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compareBeat(input string tag, input exp_t e, input logic signed [63:0] i,
                             input logic signed [63:0] q, input logic signed [63:0] ch,
                             input logic last, input logic sat);
    checkOutput({tag, "_cycle"}, cycle, e.cyc);
    checkOutput({tag, "_i"}, i, e.i);
    checkOutput({tag, "_q"}, q, e.q);
    checkOutput({tag, "_ch"}, ch, e.ch);
    checkOutput({tag, "_last"}, {63'd0, last}, {63'd0, e.last});
    checkOutput({tag, "_sat"}, {63'd0, sat}, {63'd0, e.sat});
  endtask

  function automatic exp_t mkExp(input int cyc, input longint i, input longint q,
                                 input int ch, input bit last, input bit sat);
    exp_t e;
    e.cyc = cyc; e.i = i; e.q = q; e.ch = ch; e.last = last; e.sat = sat;
    return e;
  endfunction

  // Reference: exact product, round-half-up shift, clamp to ow bits.
  function automatic void refMix(input longint d, input longint s, input int shift,
                                 input int ow, output longint r, output bit sat);
    longint p, hi, lo;
    p = d * s;
    if (shift > 0) p = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    hi  = (longint'(1) <<< (ow - 1)) - 1;
    lo  = -hi - 1;
    r   = p;
    sat = 1'b0;
    if (p > hi) begin
      r = hi; sat = 1'b1;
    end else if (p < lo) begin
      r = lo; sat = 1'b1;
    end
  endfunction

  // Drive one start strobe on instance a; returns after the accepting edge.
  task automatic applyStimulus(input logic signed [23:0] d0, input logic signed [23:0] d1,
                               input logic signed [23:0] d2, input logic signed [23:0] d3,
                               input logic signed [17:0] s, input logic signed [17:0] c);
    a_data  = {d3, d2, d1, d0};
    a_sin   = s;
    a_cos   = c;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // Model-predicted frame on instance a.
  task automatic frameA(input logic signed [23:0] d0, input logic signed [23:0] d1,
                        input logic signed [23:0] d2, input logic signed [23:0] d3,
                        input logic signed [17:0] s, input logic signed [17:0] c);
    longint dv[4];
    longint ri, rq;
    bit si, sq;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    for (int k = 0; k < 4; k++) begin
      refMix(dv[k], s, 0, 42, ri, si);
      refMix(dv[k], c, 0, 42, rq, sq);
      qa.push_back(mkExp(cycle + 3 + k, ri, rq, k, k == 3, si | sq));
    end
    applyStimulus(d0, d1, d2, d3, s, c);
  endtask

  // Scoreboard monitors: sampled on the falling edge.
  exp_t ea, eb, ec, ed;
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (qa.size() == 0) checkOutput("a_unexpected_beat", 1, 0);
      else begin
        ea = qa.pop_front();
        compareBeat("a", ea, a_i, a_q, a_ch, a_last, a_sat);
      end
    end else if (cycle > 1) begin
      checkOutput("a_idle_last_sat", {62'd0, a_last, a_sat}, 0);
    end
  end

  always @(negedge clk) begin
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) checkOutput("b_unexpected_beat", 1, 0);
      else begin
        eb = qb.pop_front();
        compareBeat("b", eb, b_i, b_q, b_ch, b_last, b_sat);
      end
    end
  end

  always @(negedge clk) begin
    if (c_valid === 1'b1) begin
      if (qc.size() == 0) checkOutput("c_unexpected_beat", 1, 0);
      else begin
        ec = qc.pop_front();
        compareBeat("c", ec, c_i, c_q, c_ch, c_last, c_sat);
      end
    end
  end

  always @(negedge clk) begin
    if (d_valid === 1'b1) begin
      if (qd.size() == 0) checkOutput("d_unexpected_beat", 1, 0);
      else begin
        ed = qd.pop_front();
        compareBeat("d", ed, d_i, d_q, d_ch, d_last, d_sat);
      end
    end else if (cycle > 1) begin
      checkOutput("d_idle_last_sat", {62'd0, d_last, d_sat}, 0);
    end
  end

  int t0;
  logic signed [23:0] rd;
  logic signed [17:0] rs, rc;
  longint ri, rq;
  bit si, sq;

  initial begin
    reset_n = 1'b0;
    a_start = 1'b0; a_data = '0; a_sin = '0; a_cos = '0;
    b_start = 1'b0; b_data = '0; b_sin = '0; b_cos = '0;
    c_start = 1'b0; c_data = '0; c_sin = '0; c_cos = '0;
    d_start = 1'b0; d_data = '0; d_sin = '0; d_cos = '0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_valid", a_valid, 0);
    checkOutput("rst_drop", a_drop, 0);
    checkOutput("rst_i", a_i, 0);
    checkOutput("rst_q", a_q, 0);
    checkOutput("rst_ch", a_ch, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed frame with full-scale channel 3; (2^23-1)*(2^17-1) for ch3 I.
    $display("[TB] basic frame");
    t0 = cycle + 1;
    qa.push_back(mkExp(t0 + 2, 64'sd131071000, -64'sd131072000, 0, 0, 0));
    qa.push_back(mkExp(t0 + 3, -64'sd131071000, 64'sd131072000, 1, 0, 0));
    qa.push_back(mkExp(t0 + 4, 64'sd0, 64'sd0, 2, 0, 0));
    qa.push_back(mkExp(t0 + 5, 64'sd1099503108097, -64'sd1099511496704, 3, 1, 0));
    applyStimulus(24'sd1000, -24'sd1000, 24'sd0, 24'sd8388607, 18'sd131071, -18'sd131072);
    checkOutput("t1_busy_set", a_busy, 1);
    repeat (5) @(negedge clk);
    checkOutput("t1_busy_clear", a_busy, 0);
    repeat (2) @(negedge clk);

    // Starts while busy are dropped; a start on the o_last edge chains.
    $display("[TB] drops and back-to-back");
    t0 = cycle + 1;
    frameA(-24'sd2000, 24'sd555, -24'sd8388608, 24'sd77, -18'sd131072, 18'sd131071);
    a_start = 1'b1; a_data = '1; a_sin = 18'sd5; a_cos = -18'sd5;
    @(negedge clk);
    checkOutput("t4_drop1", a_drop, 1);
    a_start = 1'b0;
    @(negedge clk);
    checkOutput("t4_drop_gap", a_drop, 0);
    a_start = 1'b1;
    @(negedge clk);
    checkOutput("t4_drop2", a_drop, 1);
    a_start = 1'b0;
    @(negedge clk);
    checkOutput("t4_drop_end", a_drop, 0);
    frameA(24'sd123, -24'sd456, 24'sd789, -24'sd1011, 18'sd3000, -18'sd3000);
    checkOutput("t4_b2b_busy", a_busy, 1);
    checkOutput("t4_b2b_nodrop", a_drop, 0);
    repeat (8) @(negedge clk);

    // Reset in the middle of a frame aborts the remaining beats.
    $display("[TB] reset mid-frame");
    t0 = cycle + 1;
    frameA(24'sd42, -24'sd42, 24'sd1, -24'sd1, 18'sd100, 18'sd200);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    for (int k = qa.size() - 1; k >= 0; k--) begin
      if (qa[k].cyc >= t0 + 3) qa.delete(k);
    end
    @(negedge clk);
    checkOutput("t5_valid", a_valid, 0);
    checkOutput("t5_busy", a_busy, 0);
    checkOutput("t5_i", a_i, 0);
    checkOutput("t5_q", a_q, 0);
    checkOutput("t5_ch", a_ch, 0);
    a_start = 1'b1; a_data = {4{24'sd999}};
    @(negedge clk);
    reset_n = 1'b1;
    a_start = 1'b0;
    @(negedge clk);
    checkOutput("t5_start_in_reset", a_busy, 0);
    repeat (4) @(negedge clk);
    frameA(-24'sd7, 24'sd8, -24'sd9, 24'sd10, -18'sd131072, 18'sd131071);
    repeat (6) @(negedge clk);

    // Saturation and rounding with SHIFT=10, OUT_WIDTH=24.
    $display("[TB] shift 10 saturation");
    t0 = cycle + 1;
    qb.push_back(mkExp(t0 + 2, 64'sd8388607, -64'sd8388608, 0, 0, 1));
    qb.push_back(mkExp(t0 + 3, -64'sd524288, 64'sd6144, 1, 1, 0));
    b_data = {24'sd4096, -24'sd8388608}; b_sin = -18'sd131072; b_cos = 18'sd1536;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (4) @(negedge clk);
    t0 = cycle + 1;
    qb.push_back(mkExp(t0 + 2, -64'sd8192, -64'sd6291456, 0, 0, 0));
    qb.push_back(mkExp(t0 + 3, 64'sd0, 64'sd0, 1, 1, 0));
    b_data = {24'sd0, -24'sd8388608}; b_sin = 18'sd1; b_cos = 18'sd768;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (4) @(negedge clk);

    // Round half up with SHIFT=1: -1.5 -> -1, 1.5 -> 2.
    $display("[TB] shift 1 rounding");
    t0 = cycle + 1;
    qc.push_back(mkExp(t0 + 2, -64'sd1, 64'sd2, 0, 0, 0));
    qc.push_back(mkExp(t0 + 3, 64'sd2, -64'sd1, 1, 1, 0));
    c_data = {24'sd3, -24'sd3}; c_sin = 18'sd1; c_cos = -18'sd1;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    repeat (4) @(negedge clk);

    // Single channel, random back-to-back frames against the model.
    $display("[TB] single channel random");
    for (int f = 0; f < 1000; f++) begin
      rd = 24'($urandom);
      rs = 18'($urandom);
      rc = 18'($urandom);
      if (f == 0) begin rd = -24'sd8388608; rs = -18'sd131072; rc = 18'sd131071; end
      refMix(rd, rs, 0, 42, ri, si);
      refMix(rd, rc, 0, 42, rq, sq);
      qd.push_back(mkExp(cycle + 3, ri, rq, 0, 1, si | sq));
      d_data = rd; d_sin = rs; d_cos = rc;
      d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      d_data = '1;
      checkOutput("d_busy", d_busy, 1);
      checkOutput("d_drop", d_drop, 0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    checkOutput("qa_drained", qa.size(), 0);
    checkOutput("qb_drained", qb.size(), 0);
    checkOutput("qc_drained", qc.size(), 0);
    checkOutput("qd_drained", qd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
